relm_custom_div_seq: RTL
========================

# relm_custom_div_seq

Multi-cycle integer-division sequencer for the ReLM custom datapath. It accepts one divide request, drives the datapath's DIV op once and its OPB DIVLOOP op eleven times, and feeds the datapath's A/CB results back into its own registers. It handles sign fix-up and divide-by-zero, then returns quotient and remainder over a valid/ready handshake. It sits between the ReLM core's custom-op issue logic and the combinational custom datapath.

## Interface
- WD, 32, datapath word width; only 32 is supported.
- WOP, 5, opcode width; x_out bits WOP and WOP+1 carry the rsub/sub flags.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  division request present.
- req_ready  out  1  high only in IDLE.
- req_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- req_n  in  WD  dividend.
- req_d  in  WD  divisor.
- rsp_valid  out  1  result available; held until taken.
- rsp_ready  in  1  consumer accepts the result.
- rsp_q  out  WD  quotient.
- rsp_r  out  WD  remainder.
- op_out  out  WOP  datapath opcode; low 3 bits are 3'b011 during INIT and LOOP.
- opb_out  out  1  0 in INIT, 1 in LOOP.
- x_out  out  WD+WOP  bit WOP+1 is 1 in LOOP; all other bits are 0.
- a_out / xb_out  out  WD  A and XB operands to the datapath.
- cb_out  out  2*WD  {C,B} operand to the datapath.
- a_in  in  WD  datapath A result.
- cb_in  in  2*WD  datapath {C,B} result.

## Operation
- States:
  - IDLE: req_ready=1. On req_valid, latch operands.
    - Divisor magnitude 0: go to FIX.
    - Otherwise: go to INIT.
  - INIT: drive DIV with a_out=|N| and xb_out=|D|. Register a_in into A and cb_in into {C,B}. Go to LOOP with cnt=0.
  - LOOP: drive OPB DIVLOOP with a_out=A and cb_out={C,B}. Register the results each cycle, increment cnt. Leave after cnt reaches 10 (11 iterations, 3 quotient bits each). Go to FIX.
  - FIX: compute the final values.
    - Zero divisor: q=32'hFFFFFFFF, r=req_n unchanged, for both signed and unsigned.
    - Otherwise: q=A and r=B. When signed, negate q if the operand signs differ, and negate r if the dividend is negative.
    - Go to DONE.
  - DONE: rsp_valid=1. On rsp_ready, go to IDLE.
- Magnitudes:
  - Unsigned requests pass through unchanged.
  - Signed requests use two's-complement absolute value, so INT_MIN maps to 32'h80000000 and is treated as unsigned.
- Overflow: signed INT_MIN / -1 gives q=32'h80000000 and r=0 (wraps), with no flag.
- Datapath ports:
  - Outside INIT and LOOP, op_out, opb_out and x_out are 0.
  - a_out, xb_out and cb_out hold their registered values.

## Timing
- Accept: the edge where req_valid & req_ready (state IDLE) is edge T.
- Latency, nonzero divisor: INIT at T+1, LOOP T+2..T+12, FIX T+13, rsp_valid high after edge T+14.
- Latency, zero divisor: FIX at T+1, rsp_valid high after edge T+2.
- rsp_q and rsp_r are stable for as long as rsp_valid is high. rsp_valid drops on the edge after rsp_ready is sampled high.
- req_ready returns high on the next cycle. No request is accepted in the same cycle as the response handshake.
- Datapath results are used purely combinationally within the cycle. The datapath's retry_out is ignored (always 0).
- Reset values, at any time:
  - State returns to IDLE.
  - req_ready=1, rsp_valid=0.
  - rsp_q, rsp_r, A, {C,B}, cnt, op_out, opb_out, x_out, a_out, xb_out, cb_out = 0.
  - An in-flight request is dropped silently.
- req_valid deasserting while not ready has no effect.

## Structure
- Shared package:
  - state enum: IDLE, INIT, LOOP, FIX, DONE.
  - DIV opcode 3'b011.
  - LOOP_ITER=11.
  - flag bit positions WOP and WOP+1.
- One sub-module is natural: relm_custom_div_fix, the combinational sign/zero fix-up that maps {A, B, signs, zero flag} to {q, r}.
- relm_custom is instantiated beside this block, not inside it.

## Test plan
- Unsigned 100 / 7 -> rsp_q=14, rsp_r=2, rsp_valid 14 cycles after accept; opb_out high for exactly 11 cycles.
- Unsigned 32'hFFFFFFFF / 1 -> q=32'hFFFFFFFF, r=0. Unsigned 3 / 32'h80000000 -> q=0, r=3.
- Signed -7 / 2 -> q=-3 (32'hFFFFFFFD), r=-1. Signed 7 / -2 -> q=-3, r=1. Signed INT_MIN / -1 -> q=32'h80000000, r=0.
- Divisor 0, dividend 5 (signed and unsigned) -> q=32'hFFFFFFFF, r=5, rsp_valid 2 cycles after accept, op_out stays 0.
- rsp_ready held low 5 cycles -> rsp_valid, rsp_q and rsp_r stable; req_ready stays 0; a new req_valid is not accepted.
- rst_n pulsed low during LOOP -> all outputs read 0 and req_ready=1 immediately. A following 9 / 3 returns q=3, r=0 with normal latency.

Source files
------------

// File: rtl/relm_custom_div_pkg.sv
// Shared types and constants for the ReLM custom-datapath division sequencer.
// Word/opcode widths, FSM states, DIV opcode, loop count and x_out flag positions.
package relm_custom_div_pkg;

  localparam int WD  = 32;
  localparam int WOP = 5;

  localparam logic [2:0] OP_DIV = 3'b011;

  localparam int LOOP_ITER = 11;
  localparam int CNT_W     = $clog2(LOOP_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOOP_ITER - 1);

  // Positions of the rsub/sub flags above the opcode field in x_out.
  localparam int FLAG_RSUB = WOP;
  localparam int FLAG_SUB  = WOP + 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOOP,
    FIX,
    DONE
  } state_t;

  function automatic logic [WD-1:0] neg_word(input logic [WD-1:0] v);
    return ~v + WD'(1);
  endfunction

  // Two's-complement magnitude; INT_MIN maps onto itself and is then read as unsigned.
  function automatic logic [WD-1:0] abs_mag(input logic [WD-1:0] v, input logic is_signed);
    return (is_signed && v[WD-1]) ? neg_word(v) : v;
  endfunction

endpackage

// File: rtl/relm_custom_div_fix.sv
// Combinational sign and divide-by-zero fix-up that turns the unsigned loop
// results {A, B} into the architectural quotient and remainder.
module relm_custom_div_fix
  import relm_custom_div_pkg::*;
(
  input  logic [WD-1:0] a_val,
  input  logic [WD-1:0] b_val,
  input  logic [WD-1:0] n_raw,
  input  logic          is_signed,
  input  logic          n_neg,
  input  logic          d_neg,
  input  logic          div_zero,
  output logic [WD-1:0] q,
  output logic [WD-1:0] r
);

  always_comb begin
    q = a_val;
    r = b_val;
    if (div_zero) begin
      // Divide-by-zero returns all-ones and leaves the dividend untouched.
      q = '1;
      r = n_raw;
    end else if (is_signed) begin
      if (n_neg ^ d_neg) q = neg_word(a_val);
      if (n_neg)         r = neg_word(b_val);
    end
  end

endmodule

// File: rtl/relm_custom_div_seq.sv
// Multi-cycle division sequencer: one DIV op, eleven OPB DIVLOOP ops on the
// external combinational datapath, then sign fix-up and a valid/ready response.
module relm_custom_div_seq
  import relm_custom_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_signed,
  input  logic [WD-1:0]     req_n,
  input  logic [WD-1:0]     req_d,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WD-1:0]     rsp_q,
  output logic [WD-1:0]     rsp_r,

  output logic [WOP-1:0]    op_out,
  output logic              opb_out,
  output logic [WD+WOP-1:0] x_out,
  output logic [WD-1:0]     a_out,
  output logic [WD-1:0]     xb_out,
  output logic [2*WD-1:0]   cb_out,
  input  logic [WD-1:0]     a_in,
  input  logic [2*WD-1:0]   cb_in
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WD-1:0]      a_q;
  logic [2*WD-1:0]    cb_q;
  logic [WD-1:0]      xb_q;
  logic [WD-1:0]      n_raw;
  logic               is_signed;
  logic               n_neg;
  logic               d_neg;
  logic               div_zero;
  logic [WD-1:0]      rsp_q_q;
  logic [WD-1:0]      rsp_r_q;
  logic [WD-1:0]      fix_q;
  logic [WD-1:0]      fix_r;
  logic               accept;

  assign accept = req_valid && (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_valid) state_nxt = (req_d == '0) ? FIX : INIT;
      INIT: state_nxt = LOOP;
      LOOP: if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no state leaves one
  // unassigned and infers a latch.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    op_out    = '0;
    opb_out   = 1'b0;
    x_out     = '0;
    unique case (state)
      IDLE: req_ready = 1'b1;
      INIT: op_out = WOP'(OP_DIV);
      LOOP: begin
        op_out          = WOP'(OP_DIV);
        opb_out         = 1'b1;
        x_out[FLAG_SUB] = 1'b1;
      end
      DONE: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // NOTE: every datapath register is reset so that an aborted division leaves
  // no stale operand visible on the datapath ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      cb_q      <= '0;
      xb_q      <= '0;
      cnt       <= '0;
      n_raw     <= '0;
      is_signed <= 1'b0;
      n_neg     <= 1'b0;
      d_neg     <= 1'b0;
      div_zero  <= 1'b0;
      rsp_q_q   <= '0;
      rsp_r_q   <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          a_q       <= abs_mag(req_n, req_signed);
          xb_q      <= abs_mag(req_d, req_signed);
          n_raw     <= req_n;
          is_signed <= req_signed;
          n_neg     <= req_signed & req_n[WD-1];
          d_neg     <= req_signed & req_d[WD-1];
          div_zero  <= (req_d == '0);
        end
        INIT: begin
          a_q  <= a_in;
          cb_q <= cb_in;
          cnt  <= '0;
        end
        LOOP: begin
          a_q  <= a_in;
          cb_q <= cb_in;
          cnt  <= cnt + CNT_W'(1);
        end
        FIX: begin
          rsp_q_q <= fix_q;
          rsp_r_q <= fix_r;
        end
        default: ;
      endcase
    end
  end

  relm_custom_div_fix u_fix (
    .a_val     (a_q),
    .b_val     (cb_q[WD-1:0]),
    .n_raw     (n_raw),
    .is_signed (is_signed),
    .n_neg     (n_neg),
    .d_neg     (d_neg),
    .div_zero  (div_zero),
    .q         (fix_q),
    .r         (fix_r)
  );

  assign a_out  = a_q;
  assign xb_out = xb_q;
  assign cb_out = cb_q;
  assign rsp_q  = rsp_q_q;
  assign rsp_r  = rsp_r_q;

endmodule
